// File: rtl/i2c_temp_slave_if.sv
// I2C bus signals shared by the temperature target and its bus master.
//   scl    : I2C clock driven by the master
//   sda_in : resolved SDA level as seen on the wired-AND bus
//   sda_oe : target open-drain control, 1 pulls SDA low
interface i2c_temp_slave_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_slave.sv
// I2C target exposing a temperature sensor register map.
//   clk        : 100 MHz system clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : I2C signals (scl, sda_in in; sda_oe out), slave modport
//   temp_data  : live temperature word {MSB, LSB}
//   config_reg : configuration register at pointer 0x03 ("config" is a
//                reserved SystemVerilog keyword, hence the suffix)
//   busy       : high from an address match until the next STOP or START
//
// Register map: 0x00 temp MSB, 0x01 temp LSB, 0x03 config (r/w),
// 0x0B DEV_ID, everything else reads 0x00 and ignores writes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no transfer for us; wait for START
// ADDR     | shifting in the address byte
// ADDR_ACK | driving the address ACK (first fall drives, second releases)
// RX_BYTE  | shifting in a write byte (pointer or data)
// RX_ACK   | driving the ACK for a received byte
// TX_BYTE  | shifting out a read byte, one bit per SCL fall
// TX_ACK   | released, waiting for the master ACK/NACK
module i2c_temp_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] DEV_ID   = 8'hCB
) (
  input  logic              clk,
  input  logic              rst,
  i2c_temp_slave_if.slave   bus,
  input  logic [15:0]       temp_data,
  output logic [7:0]        config_reg,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK} state_t;

  state_t      state;
  logic        scl_m, scl_s, scl_d;
  logic        sda_m, sda_s, sda_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [6:0]  tx_shift;
  logic [7:0]  ptr;
  logic [7:0]  rd_data;
  logic [7:0]  rx_byte;
  logic [15:0] snap;
  logic        rw;
  logic        ptr_loaded;
  logic        ack_seen;
  logic        sda_oe_r;
  logic        scl_rise, scl_fall, start_det, stop_det;

  assign bus.sda_oe = sda_oe_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
      sda_m <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_m <= bus.scl;    scl_s <= scl_m; scl_d <= scl_s;
      sda_m <= bus.sda_in; sda_s <= sda_m; sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shift, sda_s};

  always_comb begin
    rd_data = 8'h00;
    case (ptr)
      8'h00:   rd_data = snap[15:8];
      8'h01:   rd_data = snap[7:0];
      8'h03:   rd_data = config_reg;
      8'h0B:   rd_data = DEV_ID;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      tx_shift   <= 7'd0;
      ptr        <= 8'h00;
      snap       <= 16'h0000;
      rw         <= 1'b0;
      ptr_loaded <= 1'b0;
      ack_seen   <= 1'b0;
      sda_oe_r   <= 1'b0;
      config_reg <= 8'h00;
      busy       <= 1'b0;
    end else if (start_det) begin
      state    <= ADDR;
      bit_cnt  <= 3'd0;
      sda_oe_r <= 1'b0;
      busy     <= 1'b0;
      ack_seen <= 1'b0;
    end else if (stop_det) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      sda_oe_r <= 1'b0;
      busy     <= 1'b0;
      ack_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state      <= ADDR_ACK;
                busy       <= 1'b1;
                rw         <= rx_byte[0];
                ptr_loaded <= 1'b0;
                if (rx_byte[0]) snap <= temp_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          // sda_oe is still low on entry, so it marks which fall this is
          if (scl_fall) begin
            bit_cnt <= 3'd0;
            if (!sda_oe_r) begin
              sda_oe_r <= 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              tx_shift <= rd_data[6:0];
              sda_oe_r <= ~rd_data[7];
              state    <= TX_BYTE;
            end else begin
              sda_oe_r <= 1'b0;
              state    <= RX_BYTE;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= RX_ACK;
              if (!ptr_loaded) begin
                ptr        <= rx_byte;
                ptr_loaded <= 1'b1;
              end else begin
                if (ptr == 8'h03) config_reg <= rx_byte;
                ptr <= ptr + 8'd1;
              end
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_r <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= TX_ACK;
            end else begin
              sda_oe_r <= ~tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state <= IDLE;
            end else begin
              ptr      <= ptr + 8'd1;
              ack_seen <= 1'b1;
            end
          end else if (scl_fall && ack_seen) begin
            // next byte comes from the already-incremented pointer
            ack_seen <= 1'b0;
            tx_shift <= rd_data[6:0];
            sda_oe_r <= ~rd_data[7];
            bit_cnt  <= 3'd0;
            state    <= TX_BYTE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_temp_slave.sv
module tb_i2c_temp_slave;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] temp_data = 16'h0000;
  logic [7:0]  config_reg;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int oe_viol = 0;
  int oe_seen = 0;
  int busy_seen = 0;
  logic scl_prev = 1'b1;
  logic oe_prev = 1'b0;

  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  always #5 clk = ~clk;

  i2c_temp_slave_if bus();
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_temp_slave #(.DEV_ADDR(7'h4B), .DEV_ID(8'hCB)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .temp_data(temp_data), .config_reg(config_reg), .busy(busy)
  );

  // sda_oe may only move while SCL is low, or under reset
  always @(negedge clk) begin
    if (!rst && scl_m && scl_prev && bus.sda_oe !== oe_prev) oe_viol = oe_viol + 1;
    if (bus.sda_oe === 1'b1) oe_seen = 1;
    if (busy === 1'b1) busy_seen = 1;
    scl_prev = scl_m;
    oe_prev  = bus.sda_oe;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = bus.sda_in; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
  endtask

  // pointer byte p followed by n bytes from wbuf
  task automatic do_write(input logic [7:0] p, input int n);
    logic a;
    i2c_start();
    write_byte(8'h96, a); chk("wr_addr_ack", {15'd0, a}, 16'd1);
    write_byte(p, a);     chk("wr_ptr_ack", {15'd0, a}, 16'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a); chk("wr_data_ack", {15'd0, a}, 16'd1);
    end
    i2c_stop();
  endtask

  // read n bytes into rbuf, ACK all but the last
  task automatic do_read_raw(input int n);
    logic a;
    i2c_start();
    write_byte(8'h97, a); chk("rd_addr_ack", {15'd0, a}, 16'd1);
    for (int i = 0; i < n; i++) read_byte(rbuf[i], i != n - 1);
    chk("rd_release", {15'd0, bus.sda_oe}, 16'd0);
    i2c_stop();
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] p, input logic [15:0] t, input logic [7:0] c);
    if (p == 8'h00) return t[15:8];
    if (p == 8'h01) return t[7:0];
    if (p == 8'h03) return c;
    if (p == 8'h0B) return 8'hCB;
    return 8'h00;
  endfunction

  typedef struct {
    logic        do_wr;
    logic [7:0]  ptr;
    logic [7:0]  wdata;
    logic [15:0] temp;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_cfg;
  } vec_t;

  initial begin
    vec_t vecs [9];
    logic a, b;
    logic [7:0] d;
    logic [7:0] mcfg, mp, p;
    logic [6:0] bad;
    int n;

    vecs[0] = '{1'b1, 8'h03, 8'hA5, 16'h0C80, 8'hA5, 8'hA5};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 16'h0C80, 8'h0C, 8'hA5};
    vecs[2] = '{1'b0, 8'h01, 8'h00, 16'h0C80, 8'h80, 8'hA5};
    vecs[3] = '{1'b0, 8'h0B, 8'h00, 16'h0C80, 8'hCB, 8'hA5};
    vecs[4] = '{1'b1, 8'h0B, 8'h55, 16'h0C80, 8'hCB, 8'hA5};
    vecs[5] = '{1'b1, 8'h02, 8'h3C, 16'h0C80, 8'h00, 8'hA5};
    vecs[6] = '{1'b1, 8'h00, 8'h77, 16'h1234, 8'h12, 8'hA5};
    vecs[7] = '{1'b0, 8'hFF, 8'h00, 16'h1234, 8'h00, 8'hA5};
    vecs[8] = '{1'b1, 8'h03, 8'h00, 16'hF00D, 8'h00, 8'h00};

    repeat (4) @(posedge clk);
    #1;
    chk("reset_oe", {15'd0, bus.sda_oe}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_config", {8'd0, config_reg}, 16'h0000);
    rst = 1'b0;
    wq();

    for (int v = 0; v < 9; v++) begin
      temp_data = vecs[v].temp;
      if (vecs[v].do_wr) begin
        wbuf[0] = vecs[v].wdata;
        do_write(vecs[v].ptr, 1);
      end
      do_write(vecs[v].ptr, 0);
      do_read_raw(1);
      chk("vec_rd", {8'd0, rbuf[0]}, {8'd0, vecs[v].exp_rd});
      chk("vec_cfg", {8'd0, config_reg}, {8'd0, vecs[v].exp_cfg});
    end

    // write 0x96,0x03,0x60,STOP
    i2c_start();
    write_byte(8'h96, a); chk("w60_addr_ack", {15'd0, a}, 16'd1);
    chk("w60_busy", {15'd0, busy}, 16'd1);
    write_byte(8'h03, a); chk("w60_ptr_ack", {15'd0, a}, 16'd1);
    write_byte(8'h60, a); chk("w60_data_ack", {15'd0, a}, 16'd1);
    i2c_stop();
    chk("w60_busy_after", {15'd0, busy}, 16'd0);
    chk("w60_config", {8'd0, config_reg}, 16'h0060);

    // pointer then repeated START read of both temperature bytes
    temp_data = 16'h0C80;
    i2c_start();
    write_byte(8'h96, a); chk("sr_addr_ack", {15'd0, a}, 16'd1);
    write_byte(8'h00, a); chk("sr_ptr_ack", {15'd0, a}, 16'd1);
    i2c_start();
    write_byte(8'h97, a); chk("sr_raddr_ack", {15'd0, a}, 16'd1);
    read_byte(d, 1'b1);   chk("sr_msb", {8'd0, d}, 16'h000C);
    read_byte(d, 1'b0);   chk("sr_lsb", {8'd0, d}, 16'h0080);
    chk("sr_nack_release", {15'd0, bus.sda_oe}, 16'd0);
    i2c_stop();

    // pointer persists across transactions: ptr 0x0A, one ignored write -> 0x0B
    wbuf[0] = 8'h11;
    do_write(8'h0A, 1);
    do_read_raw(1);
    chk("persist_id", {8'd0, rbuf[0]}, 16'h00CB);

    // pointer wraps 0xFF -> 0x00 and keeps going up to config
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44; wbuf[4] = 8'h55;
    do_write(8'hFF, 5);
    chk("wrap_config", {8'd0, config_reg}, 16'h0055);

    // wrong address: never acknowledged, never driven
    oe_seen = 0; busy_seen = 0;
    i2c_start();
    write_byte(8'h90, a); chk("bad_addr_ack", {15'd0, a}, 16'd0);
    write_byte(8'h03, a); chk("bad_data_ack", {15'd0, a}, 16'd0);
    i2c_stop();
    chk("bad_oe_seen", oe_seen[15:0], 16'd0);
    chk("bad_busy_seen", busy_seen[15:0], 16'd0);

    // snapshot holds while temp_data changes mid-read
    temp_data = 16'h0C80;
    do_write(8'h00, 0);
    i2c_start();
    write_byte(8'h97, a); chk("snap_addr_ack", {15'd0, a}, 16'd1);
    read_byte(d, 1'b1);   chk("snap_msb", {8'd0, d}, 16'h000C);
    temp_data = 16'h1900;
    read_byte(d, 1'b0);   chk("snap_lsb", {8'd0, d}, 16'h0080);
    i2c_stop();

    // reset during the 4th bit of a read byte
    temp_data = 16'h0C80;
    wbuf[0] = 8'h60;
    do_write(8'h03, 1);
    do_write(8'h00, 0);
    i2c_start();
    write_byte(8'h97, a); chk("rst_addr_ack", {15'd0, a}, 16'd1);
    for (int i = 0; i < 3; i++) read_bit(b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    chk("rst_pre_oe", {15'd0, bus.sda_oe}, 16'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_oe", {15'd0, bus.sda_oe}, 16'd0);
    chk("rst_config", {8'd0, config_reg}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wq();
    scl_m = 1'b0; wq();
    oe_seen = 0;
    for (int i = 0; i < 5; i++) read_bit(b);
    chk("rst_ignore_oe", oe_seen[15:0], 16'd0);
    i2c_start();
    write_byte(8'h97, a); chk("rst_after_ack", {15'd0, a}, 16'd1);
    read_byte(d, 1'b0);   chk("rst_after_msb", {8'd0, d}, 16'h000C);
    i2c_stop();

    // randomized transactions against the register-map model
    mcfg = 8'($urandom);
    wbuf[0] = mcfg;
    do_write(8'h03, 1);
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 5))
        0: p = 8'h00;
        1: p = 8'h01;
        2: p = 8'h03;
        3: p = 8'h0B;
        4: p = 8'hFE;
        default: p = 8'($urandom);
      endcase
      n = int'($urandom_range(1, 3));
      case ($urandom_range(0, 2))
        0: begin
          mp = p;
          for (int i = 0; i < n; i++) begin
            wbuf[i] = 8'($urandom);
            if (mp == 8'h03) mcfg = wbuf[i];
            mp = mp + 8'd1;
          end
          do_write(p, n);
          chk("rnd_cfg", {8'd0, config_reg}, {8'd0, mcfg});
        end
        1: begin
          temp_data = 16'($urandom);
          do_write(p, 0);
          do_read_raw(n);
          mp = p;
          for (int i = 0; i < n; i++) begin
            chk("rnd_rd", {8'd0, rbuf[i]}, {8'd0, model_rd(mp, temp_data, mcfg)});
            mp = mp + 8'd1;
          end
        end
        default: begin
          bad = 7'($urandom);
          if (bad == 7'h4B) bad = 7'h4A;
          i2c_start();
          write_byte({bad, 1'($urandom)}, a);
          chk("rnd_bad_ack", {15'd0, a}, 16'd0);
          chk("rnd_bad_busy", {15'd0, busy}, 16'd0);
          i2c_stop();
        end
      endcase
    end

    chk("oe_only_scl_low", oe_viol[15:0], 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_temp_slave.md
I2C_TEMP_SLAVE -- requirements
Module: i2c_temp_slave

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h4B, giving the 7-bit I2C target address.
REQ-002 The block SHALL have parameter DEV_ID, default 8'hCB, giving the value returned by the ID register.
REQ-003 Port clk  input  1  system clock, 100 MHz; all logic on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port scl  input  1  I2C clock from the bus master; asynchronous to clk.
REQ-006 Port sda_in  input  1  I2C data as seen on the bus; asynchronous to clk.
REQ-007 Port sda_oe  output  1  open-drain control: 1 pulls SDA low, 0 releases it.
REQ-008 Port temp_data  input  16  live temperature word, {MSB,LSB}.
REQ-009 Port config  output  8  configuration register, writable over I2C.
REQ-010 Port busy  output  1  high from an address match until the next STOP or START.

Function
REQ-011 scl and sda_in SHALL each pass through a 2-flop synchronizer; all decoding SHALL use only the synchronized values.
REQ-012 SCL rise and fall SHALL be detected as one-cycle pulses from the synchronized value and its previous value.
REQ-013 START SHALL be detected as synchronized SDA falling while synchronized SCL is high; STOP as SDA rising while SCL is high.
REQ-014 The FSM SHALL have these states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-015 START or repeated START in any state SHALL go to ADDR with the bit count cleared and sda_oe=0.
REQ-016 STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-017 Bits SHALL be shifted in MSB first on each SCL rise.
REQ-018 After the 8th address bit:
- bits[7:1]==DEV_ADDR -> ADDR_ACK;
- otherwise -> IDLE, where the block ignores all traffic until the next START.
REQ-019 On address match with R/W=1, temp_data SHALL be snapshotted so that both bytes of one transfer are coherent.
REQ-020 ACK timing: sda_oe SHALL assert on the first SCL fall after bit 8 and deassert on the next SCL fall.
REQ-021 After an address ACK, R/W=0 SHALL go to RX_BYTE and R/W=1 SHALL go to TX_BYTE.
REQ-022 In a write transaction, the first received byte SHALL load the pointer; later bytes SHALL write the register at the pointer, then increment the pointer.
REQ-023 Every received byte SHALL be ACKed in RX_ACK using the same timing as REQ-020.
REQ-024 Register map (8-bit pointer):
- 0x00 temp MSB, read-only;
- 0x01 temp LSB, read-only;
- 0x03 config, read/write;
- 0x0B DEV_ID, read-only;
- all other pointers read 8'h00, and writes to them or to read-only registers are ignored but still ACKed.
REQ-025 TX_BYTE SHALL place each bit MSB first on an SCL fall, with bit 7 driven at the fall that ends the address ACK.
REQ-026 In TX_BYTE, sda_oe SHALL equal the inverse of the current bit (drive low for 0, release for 1).
REQ-027 After 8 transmitted bits, sda_oe SHALL release at the SCL fall, and the master ACK SHALL be sampled at the next SCL rise.
REQ-028 Master response handling:
- ACK (0): increment the pointer and send the next byte;
- NACK (1): go to IDLE and hold sda_oe=0.
REQ-029 The pointer SHALL be 8 bits, increment after each data byte read or written, and wrap from 0xFF to 0x00.
REQ-030 The pointer SHALL persist across transactions, so a read without a preceding pointer write starts at the last pointer value.
REQ-031 sda_oe SHALL never change except on an SCL fall, a detected START/STOP, or reset.

Reset
REQ-032 While rst=1 the block SHALL hold: sda_oe=0, busy=0, config=8'h00, pointer=8'h00, FSM=IDLE, synchronizers=1.
REQ-033 Asserting rst mid-transfer SHALL immediately release SDA; after release, the block SHALL ignore traffic until a new START.

Verification
REQ-034 Write 0x96,0x03,0x60,STOP -> three ACKs, config=8'h60, pointer=0x04.
REQ-035 temp_data=16'h0C80; write 0x96,0x00, Sr, 0x97, read 2 bytes (ACK, NACK) -> bytes 0x0C,0x80; SDA released after NACK.
REQ-036 Pointer=0x0B, read 0x97 and 1 byte with NACK -> byte 0xCB.
REQ-037 Address 0x90 (7'h48) -> no ACK, sda_oe stays 0 for the whole transfer, busy=0.
REQ-038 temp_data changes from 16'h0C80 to 16'h1900 between MSB and LSB of a read -> bytes 0x0C,0x80 (snapshot held).
REQ-039 rst pulsed during the 4th bit of a read byte -> sda_oe=0 within 1 clk, config=8'h00, next START/0x97 is ACKed normally.
